// File: rtl/exec_cont.sv
// Execute controller: requests instructions from fetch, reads operands from the
// local data memory, computes add/sub/mul and writes the result back to dst.
module exec_cont #(
  parameter int unsigned DATA_MEMORY_SIZE = 64,
  parameter int unsigned DATA_WIDTH       = 8,
  localparam int unsigned AW              = $clog2(DATA_MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            opcode,
  input  logic [AW-1:0]         src1,
  input  logic [AW-1:0]         src2,
  input  logic [AW-1:0]         dst,
  input  logic                  ready,
  input  logic                  finished,
  output logic                  enable,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  carry,
  output logic [15:0]           instr_count
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OPS, S_EXEC, S_WB, S_HALT
  } state_e;

  state_e                state_q;
  logic [1:0]            op_q;
  logic [AW-1:0]         src1_q, src2_q, dst_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH:0]   result_q;
  logic                  enable_q, busy_q, done_q, carry_q;
  logic [15:0]           count_q;
  logic [DATA_WIDTH-1:0] mem_q [DATA_MEMORY_SIZE];

  logic [PW-1:0]         prod_c;
  logic [DATA_WIDTH:0]   result_c;

  // Halt is decoded from the opcode, so the fetch-side finished flag is not needed.
  logic unused_finished;
  assign unused_finished = finished;

  // ALU: top bit of result carries the carry/borrow/mul-overflow flag
  always_comb begin
    prod_c   = PW'(a_q) * PW'(b_q);
    result_c = '0;
    case (op_q)
      2'b01:   result_c = {1'b0, a_q} + {1'b0, b_q};
      2'b10:   result_c = {1'b0, a_q} - {1'b0, b_q};
      2'b11:   result_c = {|prod_c[PW-1:DATA_WIDTH], prod_c[DATA_WIDTH-1:0]};
      default: result_c = '0;
    endcase
  end

  // Control FSM with registered outputs aligned to the state they describe
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DATA_MEMORY_SIZE; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (load_en) mem_q[load_addr] <= load_data;
          if (start) begin
            state_q  <= S_FETCH;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            count_q  <= '0;
          end
        end
        S_FETCH: begin
          if (ready) begin
            op_q     <= opcode;
            src1_q   <= src1;
            src2_q   <= src2;
            dst_q    <= dst;
            enable_q <= 1'b0;
            if (opcode == 2'b00) begin
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_OPS;
            end
          end
        end
        S_OPS: begin
          a_q     <= mem_q[src1_q];
          b_q     <= mem_q[src2_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= result_c;
          state_q  <= S_WB;
        end
        S_WB: begin
          mem_q[dst_q] <= result_q[DATA_WIDTH-1:0];
          carry_q      <= carry_q | result_q[DATA_WIDTH];
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
          state_q      <= S_FETCH;
          enable_q     <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign enable      = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign carry       = carry_q;
  assign instr_count = count_q;
  assign dbg_data    = mem_q[dbg_addr];

endmodule

// File: tb/tb_exec_cont.sv
// Directed testbench for exec_cont: plays the fetch side and checks memory,
// flags and handshake timing against hand-computed values.
module tb_exec_cont;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic [5:0] src1 = '0, src2 = '0, dst = '0;
  logic       ready = 1'b0;
  logic       finished = 1'b0;
  logic       enable;
  logic       load_en = 1'b0;
  logic [5:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [5:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  logic       busy, done, carry;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  exec_cont #(.DATA_MEMORY_SIZE(64), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .src1(src1), .src2(src2), .dst(dst), .ready(ready), .finished(finished),
    .enable(enable), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done),
    .carry(carry), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [5:0] addr, output logic [7:0] val);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  task automatic load(input logic [5:0] addr, input logic [7:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Fetch model: wait for enable, present one instruction, let it retire.
  task automatic issue(input logic [1:0] op, input logic [5:0] s1, input logic [5:0] s2,
                       input logic [5:0] d);
    int n = 0;
    while (enable !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL issue_enable_timeout got=%b exp=1", enable); end
    opcode = op; src1 = s1; src2 = s2; dst = d; ready = 1'b1;
    tick();
    ready = 1'b0;
    if (op != 2'b00) begin tick(); tick(); tick(); end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    for (int i = 0; i < 64; i++) begin
      peek(6'(i), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d] got=%h exp=00", i, v); end
    end
    // ready while idle must not start anything
    ready = 1'b1; opcode = 2'b01;
    tick(); tick();
    ready = 1'b0;
    checks++; if (enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored got=%b%b exp=00", enable, busy); end
  endtask

  task automatic test_add();
    logic [7:0] v;
    load(6'd1, 8'd5);
    load(6'd2, 8'd7);
    pulse_start();
    checks++; if (enable !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL add_fetch_entry got=%b%b exp=11", enable, busy); end
    opcode = 2'b01; src1 = 6'd1; src2 = 6'd2; dst = 6'd3; ready = 1'b1;
    tick();  // edge 0: FETCH->OPS
    ready = 1'b0;
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL add_enable_low got=%b exp=0", enable); end
    tick(); tick();  // edges 1,2
    peek(6'd3, v);
    checks++; if (v !== 8'd0) begin errors++; $display("FAIL add_early_write got=%h exp=00", v); end
    tick();  // edge 3: write, back to FETCH
    peek(6'd3, v);
    checks++; if (v !== 8'd12) begin errors++; $display("FAIL add_result got=%h exp=0c", v); end
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL add_refetch got=%b exp=1", enable); end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL add_count got=%0d exp=1", instr_count); end
    issue(2'b00, 6'd0, 6'd0, 6'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0 || enable !== 1'b0) begin errors++; $display("FAIL add_halt_idle got=%b%b exp=00", busy, enable); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add_carry got=%b exp=0", carry); end
  endtask

  task automatic test_sub_mul();
    logic [7:0] v;
    load(6'd0, 8'd3);
    load(6'd1, 8'd4);
    load(6'd2, 8'd16);
    pulse_start();
    checks++; if (done !== 1'b0 || enable !== 1'b1) begin errors++; $display("FAIL restart_state got=%b%b exp=01", done, enable); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL restart_count got=%0d exp=0", instr_count); end
    peek(6'd3, v);
    checks++; if (v !== 8'd12) begin errors++; $display("FAIL restart_mem_kept got=%h exp=0c", v); end
    issue(2'b10, 6'd0, 6'd1, 6'd4);
    peek(6'd4, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL sub_result got=%h exp=ff", v); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub_borrow got=%b exp=1", carry); end
    issue(2'b11, 6'd2, 6'd2, 6'd5);
    peek(6'd5, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL mul_result got=%h exp=00", v); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL mul_carry_sticky got=%b exp=1", carry); end
    checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL mul_count got=%0d exp=2", instr_count); end
    issue(2'b00, 6'd0, 6'd0, 6'd0);
  endtask

  task automatic test_stall_alias();
    logic [7:0] v;
    load(6'd6, 8'd9);
    pulse_start();
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL stall_carry_cleared got=%b exp=0", carry); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (enable !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stall_cycle%0d got=%b%b%b exp=110", i, enable, busy, done); end
    end
    issue(2'b01, 6'd6, 6'd6, 6'd6);
    peek(6'd6, v);
    checks++; if (v !== 8'd18) begin errors++; $display("FAIL alias_result got=%h exp=12", v); end
  endtask

  task automatic test_ignored();
    logic [7:0] v;
    opcode = 2'b01; src1 = 6'd1; src2 = 6'd2; dst = 6'd8; ready = 1'b1;
    tick();  // -> OPS
    ready = 1'b0;
    load_en = 1'b1; load_addr = 6'd7; load_data = 8'hAA;
    tick();  // -> EXEC, load ignored
    load_en = 1'b0;
    opcode = 2'b01; src1 = 6'd0; src2 = 6'd0; dst = 6'd9; ready = 1'b1;
    tick();  // -> WB, ready ignored
    ready = 1'b0;
    tick();  // write, -> FETCH
    tick(); tick();
    peek(6'd7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL busy_load_ignored got=%h exp=00", v); end
    peek(6'd8, v);
    checks++; if (v !== 8'd20) begin errors++; $display("FAIL ignored_add_result got=%h exp=14", v); end
    peek(6'd9, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL exec_ready_ignored got=%h exp=00", v); end
    checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL ignored_count got=%0d exp=2", instr_count); end
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL ignored_fetch_wait got=%b exp=1", enable); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    opcode = 2'b01; src1 = 6'd1; src2 = 6'd2; dst = 6'd10; ready = 1'b1;
    tick();  // -> OPS
    ready = 1'b0;
    tick();  // -> EXEC
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b%b%b exp=000", enable, busy, done); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", instr_count); end
    peek(6'd10, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL midrst_no_write got=%h exp=00", v); end
    peek(6'd6, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL midrst_mem_cleared got=%h exp=00", v); end
    // start and load in the same idle cycle: both take effect
    load_en = 1'b1; load_addr = 6'd11; load_data = 8'h5A; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    peek(6'd11, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL start_load_mem got=%h exp=5a", v); end
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL start_load_fetch got=%b exp=1", enable); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_stall_alias();
    test_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
